univ_counter_ctrl: RTL and testbench
====================================

Name: univ_counter_ctrl

Overview:
- Sequencer for the team's N-bit universal binary counter (load / up / en / sync_clr / d in; q / max_tick / min_tick out).
- On a start command it clears the counter, loads a start value and counts up or down to an end value.
- Optionally repeats the pass a programmed number of times, then pulses done.
- Sits between a host/config interface and one counter instance; it is the only driver of the counter's control inputs.

Parameters:
N, 8, counter width; must match the controlled counter.
R, 4, width of the repeat field cfg_reps.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
abort  input  1  terminate the current operation; no done.
cfg_start  input  N  first counter value of each pass.
cfg_end  input  N  terminal counter value of each pass.
cfg_up  input  1  1 = count up, 0 = count down.
cfg_reps  input  R  extra passes; total passes = cfg_reps+1.
cnt_q  input  N  counter q.
cnt_max_tick  input  1  counter max_tick.
cnt_min_tick  input  1  counter min_tick.
cnt_load  output  1  to counter load.
cnt_up  output  1  to counter up.
cnt_en  output  1  to counter en.
cnt_sync_clr  output  1  to counter sync_clr.
cnt_d  output  N  to counter d.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at normal completion.
err  output  1  one-cycle pulse on wrap abort; only with CTRL_WRAP_ABORT_EN, otherwise tied 0.
pass_idx  output  R  index of the current pass, starting at 0.

Behaviour:
Clock and reset:
- Single clock domain, clk; reset is asynchronous and active-high.
- Reset, including mid-operation, forces state IDLE and all outputs 0 (cnt_d=0, pass_idx=0).
- Reset clears the latched config registers.

Config latch:
- In IDLE with start=1, cfg_start/cfg_end/cfg_up/cfg_reps are latched at the clock edge.
- Config inputs are ignored until the next IDLE.
- start while busy is ignored.

States and transitions (Moore, except cnt_en):
- IDLE: all counter controls 0. start -> CLEAR.
- CLEAR, one cycle: cnt_sync_clr=1, cnt_en=1 -> LOAD.
- LOAD, one cycle: cnt_load=1, cnt_d=latched start -> RUN.
- RUN: cnt_up=latched dir; cnt_en = (cnt_q != latched end), combinational.
  - When cnt_q == end: if pass_idx == reps, go to DONE; else increment pass_idx and go to LOAD. No re-clear between passes.
- DONE, one cycle: done=1, pass_idx reset to 0 -> IDLE.

Output rules:
- cnt_load and cnt_sync_clr are never high in the same cycle.
- cnt_d holds the latched start in all states other than IDLE.
- cnt_up holds the latched direction while busy; it is 0 in IDLE.

Arithmetic and latency:
- Steps per pass k = (end - start) mod 2^N when counting up; (start - end) mod 2^N when counting down.
- RUN lasts k+1 cycles, with cnt_en high for exactly k of them, so the counter stops exactly on end with no overshoot.
- Single pass: done is high in cycle k+4 after the start edge.

Boundary conditions:
- start == end: k=0; RUN lasts 1 cycle, cnt_en never asserted, done still pulses.
- Wrap-around (up with end<start, or down with end>start): the counter passes through max/min and wraps modulo 2^N; allowed by default.
- abort in any non-IDLE state: next state IDLE, all counter controls 0 that edge, no done, pass_idx cleared, counter q left as is.
- abort has priority over every other transition.
- abort and start together in IDLE: abort wins; stay in IDLE.

Optional Feature:
CTRL_WRAP_ABORT_EN
- Defined: in RUN, a wrap ends the operation. A wrap is cnt_en=1 with either cnt_up=1 and cnt_max_tick=1, or cnt_up=0 and cnt_min_tick=1.
  - That cycle cnt_en is forced 0.
  - err pulses for one cycle and the state goes to IDLE; no done.
- Not defined: err is tied 0; wraps are counted through as normal steps.

Test Plan:
- Basic up: reset, then start with cfg_start=0x05, cfg_end=0x0A, cfg_up=1, cfg_reps=0 -> sync_clr 1 cycle, load 1 cycle with d=0x05, cnt_en high 5 cycles, q=0x0A, done pulses once in cycle 9, busy falls next cycle.
- Down with repeats: cfg_start=0x03, cfg_end=0x00, cfg_up=0, cfg_reps=2 -> one clear, three load/count passes of 3 en-cycles each, pass_idx 0,1,2, single done.
- Equal start/end: cfg_start=cfg_end=0x7F -> cnt_en never high, q=0x7F, done in cycle 4.
- Wrap: cfg_up=1, cfg_start=0xFE, cfg_end=0x01 -> without macro, 3 en-cycles, max_tick seen at q=0xFF, done. With CTRL_WRAP_ABORT_EN, err pulse at q=0xFF, no done, q stays 0xFF.
- Abort and reset: abort at 2nd RUN cycle -> IDLE next edge, cnt_en 0, no done, busy 0. Repeat with reset asserted mid-RUN -> all outputs 0 immediately (asynchronous). A start pulse during busy has no effect.

Source files
------------

// File: rtl/univ_counter_ctrl.sv
// Sequencer for the N-bit universal counter: clear, load a start value, count to an end value, repeat.
// Optional macro CTRL_WRAP_ABORT_EN turns a max/min wrap during RUN into an err-terminated abort.
module univ_counter_ctrl #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] cfg_start,
    input  logic [N-1:0] cfg_end,
    input  logic         cfg_up,
    input  logic [R-1:0] cfg_reps,
    input  logic [N-1:0] cnt_q,
    input  logic         cnt_max_tick,
    input  logic         cnt_min_tick,
    output logic         cnt_load,
    output logic         cnt_up,
    output logic         cnt_en,
    output logic         cnt_sync_clr,
    output logic [N-1:0] cnt_d,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [R-1:0] pass_idx
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] start_val;
    logic [N-1:0] end_val;
    logic         dir_up;
    logic [R-1:0] reps;
    logic [R-1:0] pass_next;
    logic         at_end;

`ifdef CTRL_WRAP_ABORT_EN
    logic wrap;
`else
    logic unused_ticks;
    assign unused_ticks = cnt_max_tick ^ cnt_min_tick;
`endif

    assign at_end = (cnt_q == end_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_val <= '0;
            end_val   <= '0;
            dir_up    <= 1'b0;
            reps      <= '0;
            pass_idx  <= '0;
        end else begin
            state    <= state_next;
            pass_idx <= pass_next;
            if (state == IDLE && start && !abort) begin
                start_val <= cfg_start;
                end_val   <= cfg_end;
                dir_up    <= cfg_up;
                reps      <= cfg_reps;
            end
        end
    end

    always_comb begin
        state_next   = state;
        pass_next    = pass_idx;
        cnt_load     = 1'b0;
        cnt_sync_clr = 1'b0;
        cnt_en       = 1'b0;
        cnt_up       = 1'b0;
        cnt_d        = '0;
        busy         = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
`ifdef CTRL_WRAP_ABORT_EN
        wrap         = 1'b0;
`endif

        if (state != IDLE) begin
            cnt_up = dir_up;
            cnt_d  = start_val;
        end

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                cnt_sync_clr = 1'b1;
                cnt_en       = 1'b1;
                state_next   = LOAD;
            end
            LOAD: begin
                cnt_load   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                // Enable is gated by the live compare so the counter parks exactly on end.
                cnt_en = !at_end;
                if (at_end) begin
                    if (pass_idx == reps) begin
                        state_next = DONE;
                        pass_next  = '0;
                    end else begin
                        state_next = LOAD;
                        pass_next  = pass_idx + 1'b1;
                    end
                end
`ifdef CTRL_WRAP_ABORT_EN
                wrap = cnt_en && (dir_up ? cnt_max_tick : cnt_min_tick);
                if (wrap) begin
                    cnt_en     = 1'b0;
                    err        = 1'b1;
                    state_next = IDLE;
                    pass_next  = '0;
                end
`endif
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a start seen in IDLE, and keeps q untouched.
        if (abort) begin
            state_next   = IDLE;
            pass_next    = '0;
            cnt_load     = 1'b0;
            cnt_sync_clr = 1'b0;
            cnt_en       = 1'b0;
            err          = 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_counter_ctrl.sv
// Self-checking bench for univ_counter_ctrl driving a behavioural universal counter.
// A trace model built from the pass/step arithmetic is compared against the DUT every cycle.
module tb_univ_counter_ctrl;

    localparam int N = 8;
    localparam int R = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [N-1:0] cfg_start;
    logic [N-1:0] cfg_end;
    logic         cfg_up;
    logic [R-1:0] cfg_reps;
    logic [N-1:0] cnt_q;
    logic         cnt_max_tick;
    logic         cnt_min_tick;
    logic         cnt_load;
    logic         cnt_up;
    logic         cnt_en;
    logic         cnt_sync_clr;
    logic [N-1:0] cnt_d;
    logic         busy;
    logic         done;
    logic         err;
    logic [R-1:0] pass_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    univ_counter_ctrl #(.N(N), .R(R)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_up(cfg_up), .cfg_reps(cfg_reps),
        .cnt_q(cnt_q), .cnt_max_tick(cnt_max_tick), .cnt_min_tick(cnt_min_tick),
        .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en), .cnt_sync_clr(cnt_sync_clr),
        .cnt_d(cnt_d), .busy(busy), .done(done), .err(err), .pass_idx(pass_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural universal counter the controller drives.
    always @(posedge clk or posedge reset) begin
        if (reset)             cnt_q <= '0;
        else if (cnt_sync_clr) cnt_q <= '0;
        else if (cnt_load)     cnt_q <= cnt_d;
        else if (cnt_en)       cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
    assign cnt_max_tick = (cnt_q == {N{1'b1}});
    assign cnt_min_tick = (cnt_q == '0);

    typedef struct packed {
        logic         load;
        logic         clr;
        logic         en;
        logic         up;
        logic [N-1:0] d;
        logic         busy;
        logic         done;
        logic         err;
        logic [R-1:0] pidx;
        logic         qv;
        logic [N-1:0] q;
    } exp_t;

    exp_t q_exp[$];
    exp_t cur;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-operation expected trace: clear, then per pass a load and k+1 run cycles, then done.
    function automatic void build_trace(input logic [N-1:0] s, input logic [N-1:0] e,
                                        input logic u, input logic [R-1:0] r);
        exp_t         t;
        logic [N-1:0] k;
        logic [N-1:0] qq;
        k = u ? e - s : s - e;
        t = '0; t.clr = 1'b1; t.en = 1'b1; t.up = u; t.d = s; t.busy = 1'b1;
        q_exp.push_back(t);
        for (int p = 0; p <= int'(r); p++) begin
            t = '0; t.load = 1'b1; t.up = u; t.d = s; t.busy = 1'b1; t.pidx = p[R-1:0];
            q_exp.push_back(t);
            for (int i = 0; i <= int'(k); i++) begin
                qq = u ? s + i[N-1:0] : s - i[N-1:0];
                t = '0; t.en = (i < int'(k)); t.up = u; t.d = s; t.busy = 1'b1;
                t.pidx = p[R-1:0]; t.qv = 1'b1; t.q = qq;
`ifdef CTRL_WRAP_ABORT_EN
                if (t.en && (u ? (qq == {N{1'b1}}) : (qq == '0))) begin
                    t.en = 1'b0; t.err = 1'b1;
                    q_exp.push_back(t);
                    return;
                end
`endif
                q_exp.push_back(t);
            end
        end
        t = '0; t.up = u; t.d = s; t.busy = 1'b1; t.done = 1'b1; t.qv = 1'b1; t.q = e;
        q_exp.push_back(t);
    endfunction

    initial begin
        cur = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset || abort) begin
                q_exp.delete();
                cur = '0;
            end else if (!cur.busy && start) begin
                build_trace(cfg_start, cfg_end, cfg_up, cfg_reps);
                cur = q_exp.pop_front();
            end else if (q_exp.size() > 0) begin
                cur = q_exp.pop_front();
            end else begin
                cur = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("cycle_outputs",
                {cnt_load, cnt_sync_clr, cnt_en, cnt_up, cnt_d, busy, done, err, pass_idx},
                {cur.load & ~abort, cur.clr & ~abort, cur.en & ~abort, cur.up, cur.d,
                 cur.busy, cur.done, cur.err & ~abort, cur.pidx});
            if (cur.qv) checkOutput("cycle_q", cnt_q, cur.q);
        end
    end

    task automatic applyStimulus(input logic [N-1:0] s, input logic [N-1:0] e, input logic u,
                                 input logic [R-1:0] r, input int restart_at,
                                 output int done_cyc, output int idle_cyc, output int en_cnt,
                                 output int load_cnt, output int clr_cnt, output int done_cnt,
                                 output int err_cnt, output logic max_seen);
        logic finished;
        done_cyc = -1; idle_cyc = -1; en_cnt = 0; load_cnt = 0; clr_cnt = 0;
        done_cnt = 0; err_cnt = 0; max_seen = 1'b0; finished = 1'b0;
        @(posedge clk); #1;
        cfg_start = s; cfg_end = e; cfg_up = u; cfg_reps = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_start = ~s; cfg_end = ~e; cfg_up = ~u; cfg_reps = ~r;
        for (int c = 1; c <= 300 && !finished; c++) begin
            @(negedge clk);
            if (cnt_en && !cnt_sync_clr) en_cnt++;
            if (cnt_load) load_cnt++;
            if (cnt_sync_clr) clr_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (err) err_cnt++;
            if (cnt_en && cnt_up && cnt_max_tick) max_seen = 1'b1;
            if (!busy) begin finished = 1'b1; idle_cyc = c; end
            start = (c == restart_at);
        end
        start = 1'b0;
        if (!finished) checkOutput("op_timeout", 0, 1);
    endtask

    int   dc, ic, ec, lc, cc, dn, er;
    logic mx;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_up = 1'b0; cfg_reps = '0;
        #1;
        checkOutput("reset_state",
            {cnt_load, cnt_sync_clr, cnt_en, cnt_up, cnt_d, busy, done, err, pass_idx}, 0);
        #11 reset = 1'b0;

        $display("[TB] basic up 05->0A");
        applyStimulus(8'h05, 8'h0A, 1'b1, 4'd0, 0, dc, ic, ec, lc, cc, dn, er, mx);
        checkOutput("up_done_cycle", dc, 9);
        checkOutput("up_idle_cycle", ic, 10);
        checkOutput("up_en_cycles", ec, 5);
        checkOutput("up_clear_count", cc, 1);
        checkOutput("up_done_count", dn, 1);
        checkOutput("up_final_q", cnt_q, 8'h0A);

        $display("[TB] down 03->00 with 2 repeats and a stray start");
        applyStimulus(8'h03, 8'h00, 1'b0, 4'd2, 6, dc, ic, ec, lc, cc, dn, er, mx);
        checkOutput("down_clear_count", cc, 1);
        checkOutput("down_load_count", lc, 3);
        checkOutput("down_en_cycles", ec, 9);
        checkOutput("down_done_count", dn, 1);
        checkOutput("down_done_cycle", dc, 17);
        checkOutput("down_final_q", cnt_q, 8'h00);

        $display("[TB] equal start/end 7F");
        applyStimulus(8'h7F, 8'h7F, 1'b1, 4'd0, 0, dc, ic, ec, lc, cc, dn, er, mx);
        checkOutput("eq_done_cycle", dc, 4);
        checkOutput("eq_en_cycles", ec, 0);
        checkOutput("eq_final_q", cnt_q, 8'h7F);

        $display("[TB] wrap FE->01 up");
        applyStimulus(8'hFE, 8'h01, 1'b1, 4'd0, 0, dc, ic, ec, lc, cc, dn, er, mx);
`ifdef CTRL_WRAP_ABORT_EN
        checkOutput("wrap_err_count", er, 1);
        checkOutput("wrap_done_count", dn, 0);
        checkOutput("wrap_final_q", cnt_q, 8'hFF);
`else
        checkOutput("wrap_en_cycles", ec, 3);
        checkOutput("wrap_max_seen", mx, 1);
        checkOutput("wrap_done_count", dn, 1);
        checkOutput("wrap_err_count", er, 0);
        checkOutput("wrap_final_q", cnt_q, 8'h01);
`endif

        $display("[TB] abort in second RUN cycle");
        @(posedge clk); #1;
        cfg_start = 8'h10; cfg_end = 8'h20; cfg_up = 1'b1; cfg_reps = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("abort_pre_q", cnt_q, 8'h11);
        abort = 1'b1;
        #1 checkOutput("abort_en_gated", cnt_en, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pass_idx", pass_idx, 0);
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        checkOutput("abort_no_done", dn, 0);
        checkOutput("abort_q_held", cnt_q, 8'h11);

        $display("[TB] abort together with start in IDLE");
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_start_idle", busy, 0);

        $display("[TB] reset mid-RUN");
        @(posedge clk); #1;
        cfg_start = 8'h20; cfg_end = 8'h40; cfg_up = 1'b1; cfg_reps = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("prereset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_outputs",
            {cnt_load, cnt_sync_clr, cnt_en, cnt_up, cnt_d, busy, done, err, pass_idx}, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h00, 8'h03, 1'b1, 4'd0, 0, dc, ic, ec, lc, cc, dn, er, mx);
        checkOutput("post_reset_done_cycle", dc, 7);
        checkOutput("post_reset_q", cnt_q, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
